mul_shift_add: RTL and testbench
================================

MUL_SHIFT_ADD -- requirements
Module: mul_shift_add

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have port sgn, input, 1 bit: mode select; 0 = unsigned operands, 1 = two's-complement operands.
REQ-006 The block SHALL have ports x and y, inputs, N bits each: multiplicand and multiplier.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking out valid.
REQ-009 The block SHALL have port out, output, 2N bits: registered product.

Function
REQ-010 The block SHALL implement states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1, the block SHALL, at that edge:
- latch x, y and sgn;
- in signed mode, convert each operand to its magnitude and record the product sign as x[N-1] XOR y[N-1];
- clear the accumulator and iteration counter;
- enter RUN.
REQ-012 Each RUN cycle SHALL process one multiplier bit, LSB first: if the bit is 1, add the shifted multiplicand to the 2N-bit accumulator; then shift.
REQ-013 After exactly N RUN cycles the block SHALL enter DONE.
REQ-014 In DONE, the block SHALL:
- load out with the accumulator, two's-complement negated if the recorded product sign is 1 in signed mode;
- assert done for exactly that one cycle;
- return to IDLE on the next edge.
REQ-015 done SHALL be high exactly N+1 cycles after the edge that accepted start; busy SHALL be high in RUN and DONE and low in IDLE.
REQ-016 start SHALL be ignored outside IDLE, including during the DONE cycle; the in-flight operation and latched operands SHALL be unaffected.
REQ-017 Changes on x, y or sgn after acceptance SHALL NOT affect the result.
REQ-018 out SHALL hold its value from DONE until the next DONE; it SHALL NOT change during RUN.
REQ-019 Arithmetic SHALL be exact in 2N bits with no overflow for all inputs, including signed -2^(N-1) x -2^(N-1) = +2^(2N-2).
REQ-020 A zero operand SHALL still take the full N+1-cycle latency (no early termination).
REQ-021 start held continuously high SHALL produce back-to-back operations:
- a new acceptance occurs in the IDLE cycle following DONE;
- throughput is one result per N+2 cycles.

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL set state IDLE, busy=0, done=0, out=0, and clear the accumulator, counter and latched operands.
REQ-023 rst SHALL take priority over start.
REQ-024 Reset during RUN or DONE SHALL abort the operation with no done pulse.

Structure
REQ-025 A shared package mul_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the counter-width function clog2(N+1).
REQ-026 The block SHALL be a single module with no sub-module required; the magnitude/negate logic MAY be factored into sub-module mul_absval (N-bit two's-complement magnitude).

Verification
REQ-027 The bench SHALL cover the following directed scenarios with N=8, in addition to the random check in REQ-028:
- sgn=0, x=255, y=255, start one cycle -> done at cycle 9 after acceptance, out=0xFE01, busy high for 9 cycles.
- sgn=1, x=0x80, y=0x80 -> out=0x4000.
- sgn=1, x=0xFD (-3), y=0x05 -> out=0xFFF1.
- sgn=0, x=0, y=0xAA -> out=0x0000, done still at cycle 9.
- Accept 12x10; pulse start with x=1, y=1 at cycle 4; also pulse start in the DONE cycle -> out=120, single done pulse, second request ignored.
- Accept 7x9, assert rst at cycle 5 -> no done, busy=0 and out=0 next cycle; then 7x9 -> out=63.
REQ-028 The bench SHALL also run 1000 random operations in each mode, checking out against a reference product, for both N=8 and N=4 (N=4: 15x15 = 225).

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2; the iteration counter is sized clog2(N+1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_absval.sv
// N-bit two's-complement magnitude; passes the operand through when en_i is low.
module mul_absval #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic         en_i,
    output logic [N-1:0] mag_o
);

    // -2^(N-1) maps to 2^(N-1), which still fits as an unsigned N-bit value.
    always_comb begin
        mag_o = a_i;
        if (en_i && a_i[N-1]) begin
            mag_o = ~a_i + {{(N-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mul_shift_add.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle, signed or unsigned.
module mul_shift_add
    import mul_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] out
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned CW = clog2(N + 1);

    state_e         state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   out_q, out_d;

    logic [N-1:0]   x_mag, y_mag;
    logic [W-1:0]   acc_nxt;

    mul_absval #(.N(N)) u_abs_x (
        .a_i   (x),
        .en_i  (sgn),
        .mag_o (x_mag)
    );

    mul_absval #(.N(N)) u_abs_y (
        .a_i   (y),
        .en_i  (sgn),
        .mag_o (y_mag)
    );

    // Next-state: latch magnitudes on accept, add/shift in RUN, publish product on the last step.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        acc_nxt  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{N{1'b0}}, x_mag};
                    mplier_d = y_mag;
                    neg_d    = sgn & (x[N-1] ^ y[N-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    // Loaded on entry to DONE so out is already valid while done is high.
                    out_d   = neg_q ? (~acc_nxt + W'(1)) : acc_nxt;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign out  = out_q;

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add at N=8 and N=4.
module tb_mul_shift_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b1, start8 = 1'b0, sgn8 = 1'b0, busy8, done8;
    logic [7:0]  x8 = '0, y8 = '0;
    logic [15:0] out8;
    logic        rst4 = 1'b1, start4 = 1'b0, sgn4 = 1'b0, busy4, done4;
    logic [3:0]  x4 = '0, y4 = '0;
    logic [7:0]  out4;

    int n_tests = 0;
    int n_fail  = 0;

    mul_shift_add #(.N(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .sgn(sgn8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .out(out8)
    );

    mul_shift_add #(.N(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .sgn(sgn4), .x(x4), .y(y4),
        .busy(busy4), .done(done4), .out(out4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product of two n-bit operands, truncated to 2n bits.
    function automatic longint prod(input int n, input bit s, input longint a, input longint b);
        longint mask;
        mask = (longint'(1) << (2 * n)) - 1;
        if (s) begin
            if (a[n-1]) a = a - (longint'(1) << n);
            if (b[n-1]) b = b - (longint'(1) << n);
        end
        return (a * b) & mask;
    endfunction

    // Reference model: an accepted op keeps the block busy for N+1 cycles, the last with done.
    int          m8_left = 0, m8_acc = 0, m4_left = 0, m4_acc = 0;
    logic [15:0] m8_pend = '0, m8_out = '0;
    logic [7:0]  m4_pend = '0, m4_out = '0;
    bit          en8 = 1'b0, en4 = 1'b0;

    always @(posedge clk) begin
        if (rst8) begin
            m8_left <= 0;
            m8_out  <= '0;
        end else if (m8_left == 0) begin
            if (start8) begin
                m8_left <= 9;
                m8_pend <= 16'(prod(8, sgn8, longint'(x8), longint'(y8)));
                m8_acc  <= m8_acc + 1;
            end
        end else begin
            m8_left <= m8_left - 1;
            if (m8_left == 2) m8_out <= m8_pend;
        end
    end

    always @(posedge clk) begin
        if (rst4) begin
            m4_left <= 0;
            m4_out  <= '0;
        end else if (m4_left == 0) begin
            if (start4) begin
                m4_left <= 5;
                m4_pend <= 8'(prod(4, sgn4, longint'(x4), longint'(y4)));
                m4_acc  <= m4_acc + 1;
            end
        end else begin
            m4_left <= m4_left - 1;
            if (m4_left == 2) m4_out <= m4_pend;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (en8) begin
            check("busy8", 64'(busy8), 64'(m8_left != 0));
            check("done8", 64'(done8), 64'(m8_left == 1));
            check("out8",  64'(out8),  64'(m8_out));
        end
        if (en4) begin
            check("busy4", 64'(busy4), 64'(m4_left != 0));
            check("done4", 64'(done4), 64'(m4_left == 1));
            check("out4",  64'(out4),  64'(m4_out));
        end
    end

    // Single operation; lat counts cycles after acceptance until done, nb the busy cycles seen.
    task automatic run_op(input bit wide, input bit s, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] res, output int lat, output int nb);
        @(negedge clk);
        if (wide) begin sgn8 = s; x8 = a; y8 = b; start8 = 1'b1; end
        else begin sgn4 = s; x4 = a[3:0]; y4 = b[3:0]; start4 = 1'b1; end
        @(negedge clk);
        // Scramble operands after acceptance; the result must not change.
        if (wide) begin start8 = 1'b0; sgn8 = ~s; x8 = ~a; y8 = 8'($urandom); end
        else begin start4 = 1'b0; sgn4 = ~s; x4 = ~a[3:0]; y4 = 4'($urandom); end
        lat = 1;
        nb  = 0;
        while (1) begin
            if (wide ? busy8 : busy4) nb++;
            if ((wide ? done8 : done4) || lat >= 40) break;
            @(negedge clk);
            lat++;
        end
        res = wide ? out8 : {8'h00, out4};
    endtask

    task automatic rand8(input bit s, input int target);
        int base, guard;
        base  = m8_acc;
        guard = 0;
        while (m8_acc - base < target && guard < 30000) begin
            @(negedge clk);
            sgn8 = s; x8 = 8'($urandom); y8 = 8'($urandom);
            start8 = ($urandom_range(0, 3) != 0);
            guard++;
        end
        @(negedge clk);
        start8 = 1'b0;
        check("rand8_ops", 64'(m8_acc - base >= target), 64'd1);
        repeat (12) @(negedge clk);
    endtask

    task automatic rand4(input bit s, input int target);
        int base, guard;
        base  = m4_acc;
        guard = 0;
        while (m4_acc - base < target && guard < 20000) begin
            @(negedge clk);
            sgn4 = s; x4 = 4'($urandom); y4 = 4'($urandom);
            start4 = ($urandom_range(0, 3) != 0);
            guard++;
        end
        @(negedge clk);
        start4 = 1'b0;
        check("rand4_ops", 64'(m4_acc - base >= target), 64'd1);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res;
        int lat, nb, ndone;

        repeat (2) @(negedge clk);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_out8",  64'(out8),  64'd0);
        check("rst_out4",  64'(out4),  64'd0);
        rst8 = 1'b0;
        rst4 = 1'b0;
        en8  = 1'b1;
        en4  = 1'b1;

        run_op(1'b1, 1'b0, 8'd255, 8'd255, res, lat, nb);
        check("uu_ff_out", 64'(res), 64'hFE01);
        check("uu_ff_lat", 64'(lat), 64'd9);
        check("uu_ff_busy", 64'(nb), 64'd9);
        @(negedge clk);
        check("uu_ff_idle", 64'(busy8), 64'd0);

        run_op(1'b1, 1'b1, 8'h80, 8'h80, res, lat, nb);
        check("ss_min_out", 64'(res), 64'h4000);

        run_op(1'b1, 1'b1, 8'hFD, 8'h05, res, lat, nb);
        check("ss_neg_out", 64'(res), 64'hFFF1);
        check("ss_neg_lat", 64'(lat), 64'd9);

        run_op(1'b1, 1'b0, 8'h00, 8'hAA, res, lat, nb);
        check("zero_out", 64'(res), 64'h0000);
        check("zero_lat", 64'(lat), 64'd9);

        // 12x10 with ignored start pulses at cycle 4 and in the DONE cycle.
        @(negedge clk);
        sgn8 = 1'b0; x8 = 8'd12; y8 = 8'd10; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        start8 = 1'b1; x8 = 8'd1; y8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 5;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("ign_out", 64'(out8), 64'd120);
        check("ign_lat", 64'(lat), 64'd9);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ndone = 0;
        repeat (12) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        check("ign_no_done", 64'(ndone), 64'd0);
        check("ign_out_hold", 64'(out8), 64'd120);

        // Reset mid-operation aborts it.
        @(negedge clk);
        sgn8 = 1'b0; x8 = 8'd7; y8 = 8'd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_out",  64'(out8),  64'd0);
        ndone = 0;
        repeat (12) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        run_op(1'b1, 1'b0, 8'd7, 8'd9, res, lat, nb);
        check("after_abort", 64'(res), 64'd63);

        fork
            begin
                rand8(1'b0, 1000);
                rand8(1'b1, 1000);
            end
            begin
                run_op(1'b0, 1'b0, 8'h0F, 8'h0F, res, lat, nb);
                check("n4_uu_out", 64'(res), 64'd225);
                check("n4_uu_lat", 64'(lat), 64'd5);
                run_op(1'b0, 1'b1, 8'h08, 8'h08, res, lat, nb);
                check("n4_ss_min", 64'(res), 64'd64);
                run_op(1'b0, 1'b1, 8'h0F, 8'h03, res, lat, nb);
                check("n4_ss_neg", 64'(res), 64'hFD);
                rand4(1'b0, 1000);
                rand4(1'b1, 1000);
            end
        join

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
